// File: rtl/arbitrare_rr.sv
// -----------------------------------------------------------------------------
// arbitrare_rr
//
// N-client req/ack bus arbiter. One requester is selected per transaction
// (round-robin or fixed lowest-index priority), its payload is captured and
// forwarded downstream tagged with its client index, and the downstream ack
// payload is returned to that client as a one-cycle ack pulse.
//
// Transaction flow: IDLE -> GRANT (winner_req held until winner_ack)
//                   -> RESP (client_ack pulse, one cycle) -> IDLE.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous reset, active high
//   client_req       per-client request level (bit i = client i)
//   client_data_req  packed client payloads, client i at [i*W +: W]
//   client_ack       one-cycle ack pulse to the granted client (onehot0)
//   client_data_ack  ack payload, meaningful while a client_ack bit is high
//   winner_req       downstream request, held until winner_ack
//   winner_data_req  {winner id, captured payload}
//   winner_ack       downstream acknowledge pulse
//   winner_data_ack  downstream ack payload, valid with winner_ack
//   busy             high while a transaction is in GRANT or RESP
// -----------------------------------------------------------------------------
module arbitrare_rr #(
    parameter int NUM_CLIENTS    = 4,
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int PRIORITY_MODE  = 0,
    localparam int ID_WIDTH      = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CLIENTS-1:0]                 client_req,
    input  logic [NUM_CLIENTS*REQ_DATA_WIDTH-1:0]  client_data_req,
    output logic [NUM_CLIENTS-1:0]                 client_ack,
    output logic [ACK_DATA_WIDTH-1:0]              client_data_ack,
    output logic                                   winner_req,
    output logic [ID_WIDTH+REQ_DATA_WIDTH-1:0]     winner_data_req,
    input  logic                                   winner_ack,
    input  logic [ACK_DATA_WIDTH-1:0]              winner_data_ack,
    output logic                                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
    logic                        mask_valid_q, mask_valid_d;
    logic [ID_WIDTH-1:0]         win_id_q, win_id_d;
    logic [REQ_DATA_WIDTH-1:0]   win_data_q, win_data_d;
    logic                        winner_req_q, winner_req_d;
    logic [NUM_CLIENTS-1:0]      client_ack_q, client_ack_d;
    logic [ACK_DATA_WIDTH-1:0]   client_data_ack_q, client_data_ack_d;
    logic                        busy_q, busy_d;

    logic [NUM_CLIENTS-1:0]      id_onehot;
    logic [NUM_CLIENTS-1:0]      mask_vec;
    logic [NUM_CLIENTS-1:0]      eff_req;
    logic [REQ_DATA_WIDTH-1:0]   payload [NUM_CLIENTS];

    logic                        pick_found;
    logic [ID_WIDTH-1:0]         pick_id;
    logic [ID_WIDTH:0]           idx;

    // win_id_q doubles as the last-served id once the transaction ends, so the
    // same one-hot drives both the ack pulse and the post-RESP mask.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        assign id_onehot[gi] = (win_id_q == ID_WIDTH'(gi));
        assign mask_vec[gi]  = mask_valid_q & id_onehot[gi];
        assign payload[gi]   = client_data_req[gi*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
    end

    assign eff_req = client_req & ~mask_vec;

    // Winner selection. Loops run from lowest to highest priority and let
    // later hits overwrite earlier ones, so the last hit is the winner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        if (PRIORITY_MODE != 0) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (eff_req[i]) begin
                    pick_found = 1'b1;
                    pick_id    = ID_WIDTH'(i);
                end
            end
        end else begin
            // Offset k = 1 (just after rr_ptr) has the highest priority.
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                idx = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
                if (idx >= (ID_WIDTH+1)'(NUM_CLIENTS)) begin
                    idx = idx - (ID_WIDTH+1)'(NUM_CLIENTS);
                end
                if (eff_req[idx[ID_WIDTH-1:0]]) begin
                    pick_found = 1'b1;
                    pick_id    = idx[ID_WIDTH-1:0];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_found) state_d = ST_GRANT;
            ST_GRANT: if (winner_ack) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        rr_ptr_d          = rr_ptr_q;
        mask_valid_d      = mask_valid_q;
        win_id_d          = win_id_q;
        win_data_d        = win_data_q;
        winner_req_d      = winner_req_q;
        client_ack_d      = client_ack_q;
        client_data_ack_d = client_data_ack_q;
        busy_d            = busy_q;
        case (state_q)
            ST_IDLE: begin
                // The mask only ever covers the first IDLE cycle after RESP.
                mask_valid_d = 1'b0;
                if (pick_found) begin
                    win_id_d     = pick_id;
                    win_data_d   = payload[pick_id];
                    winner_req_d = 1'b1;
                    busy_d       = 1'b1;
                    rr_ptr_d     = pick_id;
                end
            end
            ST_GRANT: begin
                if (winner_ack) begin
                    client_data_ack_d = winner_data_ack;
                    client_ack_d      = id_onehot;
                    winner_req_d      = 1'b0;
                end
            end
            ST_RESP: begin
                client_ack_d      = '0;
                client_data_ack_d = '0;
                busy_d            = 1'b0;
                mask_valid_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q          <= ID_WIDTH'(NUM_CLIENTS - 1);
            mask_valid_q      <= 1'b0;
            win_id_q          <= '0;
            win_data_q        <= '0;
            winner_req_q      <= 1'b0;
            client_ack_q      <= '0;
            client_data_ack_q <= '0;
            busy_q            <= 1'b0;
        end else begin
            rr_ptr_q          <= rr_ptr_d;
            mask_valid_q      <= mask_valid_d;
            win_id_q          <= win_id_d;
            win_data_q        <= win_data_d;
            winner_req_q      <= winner_req_d;
            client_ack_q      <= client_ack_d;
            client_data_ack_q <= client_data_ack_d;
            busy_q            <= busy_d;
        end
    end

    assign client_ack      = client_ack_q;
    assign client_data_ack = client_data_ack_q;
    assign winner_req      = winner_req_q;
    assign winner_data_req = {win_id_q, win_data_q};
    assign busy            = busy_q;

endmodule

// File: tb/tb_arbitrare_rr.sv
// -----------------------------------------------------------------------------
// tb_arbitrare_rr
//
// Three arbiter instances: A (4 clients, round-robin), B (4 clients, fixed
// priority), C (2 clients, 16-bit payload). Stimulus pushes expected grants
// and acks into queues; a monitor pops and compares whenever a DUT raises
// winner_req or pulses client_ack. A responder answers each winner_req after
// a programmable delay with winner_data_ack = base + winner id.
// -----------------------------------------------------------------------------
module tb_arbitrare_rr;

    typedef struct {
        int          dut;
        logic [31:0] val;
        int          gap;   // expected cycles since previous grant, 0 = any
    } grant_t;

    typedef struct {
        int          dut;
        logic [3:0]  onehot;
        logic [7:0]  data;
    } ack_t;

    logic clk;
    logic rst;

    // DUT A
    logic [3:0]  a_req;
    logic [31:0] a_data;
    logic [3:0]  a_ack;
    logic [7:0]  a_dack;
    logic        a_wreq;
    logic [9:0]  a_wdata;
    logic        a_wack;
    logic [7:0]  a_wdack;
    logic        a_busy;
    // DUT B
    logic [3:0]  b_req;
    logic [31:0] b_data;
    logic [3:0]  b_ack;
    logic [7:0]  b_dack;
    logic        b_wreq;
    logic [9:0]  b_wdata;
    logic        b_wack;
    logic [7:0]  b_wdack;
    logic        b_busy;
    // DUT C
    logic [1:0]  c_req;
    logic [31:0] c_data;
    logic [1:0]  c_ack;
    logic [7:0]  c_dack;
    logic        c_wreq;
    logic [16:0] c_wdata;
    logic        c_wack;
    logic [7:0]  c_wdack;
    logic        c_busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    grant_t exp_grant[$];
    ack_t   exp_ack[$];

    logic        wreq_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  ack_v   [3];
    logic [7:0]  dack_v  [3];
    logic        wack_r  [3];
    int          rsp_cnt [3];
    int          rsp_delay [3];
    logic [7:0]  rsp_base [3];
    logic        stray_ack;

    arbitrare_rr #(.NUM_CLIENTS(4), .REQ_DATA_WIDTH(8), .ACK_DATA_WIDTH(8), .PRIORITY_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .client_req(a_req), .client_data_req(a_data),
        .client_ack(a_ack), .client_data_ack(a_dack), .winner_req(a_wreq),
        .winner_data_req(a_wdata), .winner_ack(a_wack), .winner_data_ack(a_wdack),
        .busy(a_busy));

    arbitrare_rr #(.NUM_CLIENTS(4), .REQ_DATA_WIDTH(8), .ACK_DATA_WIDTH(8), .PRIORITY_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .client_req(b_req), .client_data_req(b_data),
        .client_ack(b_ack), .client_data_ack(b_dack), .winner_req(b_wreq),
        .winner_data_req(b_wdata), .winner_ack(b_wack), .winner_data_ack(b_wdack),
        .busy(b_busy));

    arbitrare_rr #(.NUM_CLIENTS(2), .REQ_DATA_WIDTH(16), .ACK_DATA_WIDTH(8), .PRIORITY_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .client_req(c_req), .client_data_req(c_data[31:0]),
        .client_ack(c_ack), .client_data_ack(c_dack), .winner_req(c_wreq),
        .winner_data_req(c_wdata), .winner_ack(c_wack), .winner_data_ack(c_wdack),
        .busy(c_busy));

    assign wreq_v[0]  = a_wreq;
    assign wreq_v[1]  = b_wreq;
    assign wreq_v[2]  = c_wreq;
    assign wdata_v[0] = {22'b0, a_wdata};
    assign wdata_v[1] = {22'b0, b_wdata};
    assign wdata_v[2] = {15'b0, c_wdata};
    assign ack_v[0]   = a_ack;
    assign ack_v[1]   = b_ack;
    assign ack_v[2]   = {2'b0, c_ack};
    assign dack_v[0]  = a_dack;
    assign dack_v[1]  = b_dack;
    assign dack_v[2]  = c_dack;

    assign a_wack  = wack_r[0] | stray_ack;
    assign b_wack  = wack_r[1];
    assign c_wack  = wack_r[2];
    assign a_wdack = rsp_base[0] + {6'b0, a_wdata[9:8]};
    assign b_wdack = rsp_base[1] + {6'b0, b_wdata[9:8]};
    assign c_wdack = rsp_base[2] + {7'b0, c_wdata[16]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Downstream responder: raises winner_ack for one cycle once winner_req
    // has been seen for more than rsp_delay falling edges.
    initial begin
        for (int d = 0; d < 3; d++) begin
            wack_r[d]  = 1'b0;
            rsp_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (wack_r[d]) begin
                    wack_r[d] = 1'b0;
                end else if (wreq_v[d]) begin
                    rsp_cnt[d]++;
                    if (rsp_cnt[d] > rsp_delay[d]) begin
                        wack_r[d]  = 1'b1;
                        rsp_cnt[d] = 0;
                    end
                end else begin
                    rsp_cnt[d] = 0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_wreq [3];
        int   last_rise [3];
        grant_t g;
        ack_t   a;
        for (int d = 0; d < 3; d++) begin
            prev_wreq[d] = 1'b0;
            last_rise[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (wreq_v[d] && !prev_wreq[d]) begin
                    if (exp_grant.size() == 0) begin
                        check($sformatf("unexpected_grant dut%0d", d), wdata_v[d], 32'hFFFF_FFFF);
                    end else begin
                        g = exp_grant.pop_front();
                        check($sformatf("grant_dut dut%0d", d), d, g.dut);
                        check($sformatf("grant_data dut%0d", d), wdata_v[d], g.val);
                        if (g.gap != 0) begin
                            check($sformatf("grant_gap dut%0d", d), cycle - last_rise[d], g.gap);
                        end
                    end
                    last_rise[d] = cycle;
                end
                prev_wreq[d] = wreq_v[d];
                if (ack_v[d] != 4'b0) begin
                    check($sformatf("ack_onehot0 dut%0d", d), {31'b0, $onehot0(ack_v[d])}, 32'd1);
                    if (exp_ack.size() == 0) begin
                        check($sformatf("unexpected_ack dut%0d", d), {28'b0, ack_v[d]}, 32'd0);
                    end else begin
                        a = exp_ack.pop_front();
                        check($sformatf("ack_dut dut%0d", d), d, a.dut);
                        check($sformatf("ack_vec dut%0d", d), {28'b0, ack_v[d]}, {28'b0, a.onehot});
                        check($sformatf("ack_data dut%0d", d), {24'b0, dack_v[d]}, {24'b0, a.data});
                    end
                end
            end
        end
    end

    task automatic push_txn(input int d, input logic [31:0] val, input int gap,
                            input logic [3:0] onehot, input logic [7:0] data);
        grant_t g;
        ack_t   a;
        g.dut = d; g.val = val; g.gap = gap;
        a.dut = d; a.onehot = onehot; a.data = data;
        exp_grant.push_back(g);
        exp_ack.push_back(a);
    endtask

    task automatic wait_acks(input int d, input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack_v[d] != 4'b0) seen++;
        end
        check($sformatf("ack_count dut%0d", d), seen, n);
    endtask

    task automatic wait_wreq(input int d, input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wreq_v[d] && cyc < budget);
        check($sformatf("wreq_seen dut%0d", d), {31'b0, wreq_v[d]}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        stray_ack = 1'b0;
        a_req = '0; a_data = '0;
        b_req = '0; b_data = '0;
        c_req = '0; c_data = '0;
        for (int d = 0; d < 3; d++) begin
            rsp_delay[d] = 0;
            rsp_base[d]  = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_a_wreq",  {31'b0, a_wreq}, 32'd0);
        check("rst_a_busy",  {31'b0, a_busy}, 32'd0);
        check("rst_a_ack",   {28'b0, a_ack}, 32'd0);
        check("rst_a_dack",  {24'b0, a_dack}, 32'd0);
        check("rst_a_wdata", {22'b0, a_wdata}, 32'd0);
        check("rst_c_wdata", {15'b0, c_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, ack 2 cycles after winner_req
        rsp_delay[0] = 2;
        rsp_base[0]  = 8'h3A;
        a_data[23:16] = 8'hA5;
        push_txn(0, 32'h2A5, 0, 4'b0100, 8'h3C);
        a_req = 4'b0100;
        @(negedge clk);
        check("latency_wreq", {31'b0, a_wreq}, 32'd1);
        check("latency_busy", {31'b0, a_busy}, 32'd1);
        wait_acks(0, 1, 20);
        a_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Round-robin fairness from reset: 0,1,2,3,0
        do_reset();
        rsp_delay[0] = 0;
        rsp_base[0]  = 8'h50;
        a_data = {8'h13, 8'h12, 8'h11, 8'h10};
        push_txn(0, 32'h010, 0, 4'b0001, 8'h50);
        push_txn(0, 32'h111, 3, 4'b0010, 8'h51);
        push_txn(0, 32'h212, 3, 4'b0100, 8'h52);
        push_txn(0, 32'h313, 3, 4'b1000, 8'h53);
        push_txn(0, 32'h010, 3, 4'b0001, 8'h50);
        a_req = 4'b1111;
        wait_acks(0, 5, 60);
        a_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Fixed priority with mask: 0,1,0,1 then client 0 alone
        rsp_delay[1] = 0;
        rsp_base[1]  = 8'h70;
        b_data = {8'h00, 8'h00, 8'hC1, 8'hC0};
        push_txn(1, 32'h0C0, 0, 4'b0001, 8'h70);
        push_txn(1, 32'h1C1, 3, 4'b0010, 8'h71);
        push_txn(1, 32'h0C0, 3, 4'b0001, 8'h70);
        push_txn(1, 32'h1C1, 3, 4'b0010, 8'h71);
        b_req = 4'b0011;
        wait_acks(1, 4, 60);
        push_txn(1, 32'h0C0, 3, 4'b0001, 8'h70);
        push_txn(1, 32'h0C0, 4, 4'b0001, 8'h70);
        b_req = 4'b0001;
        wait_acks(1, 2, 40);
        b_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Stray winner_ack while IDLE
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_ack",  {28'b0, a_ack}, 32'd0);
        check("stray_busy", {31'b0, a_busy}, 32'd0);
        check("stray_wreq", {31'b0, a_wreq}, 32'd0);
        @(negedge clk);
        check("stray_ack_later", {28'b0, a_ack}, 32'd0);

        // Client drops req during GRANT; ack still delivered
        rsp_delay[0] = 2;
        rsp_base[0]  = 8'h90;
        a_data[31:24] = 8'h77;
        push_txn(0, 32'h377, 0, 4'b1000, 8'h93);
        a_req = 4'b1000;
        wait_wreq(0, 10);
        a_req = 4'b0000;
        wait_acks(0, 1, 20);
        repeat (2) @(negedge clk);

        // Reset mid-transaction, then client 1 first with 4'b1010
        rsp_delay[0] = 100;
        a_data[23:16] = 8'hA5;
        begin
            grant_t g;
            g.dut = 0; g.val = 32'h2A5; g.gap = 0;
            exp_grant.push_back(g);
        end
        a_req = 4'b0100;
        wait_wreq(0, 10);
        rst = 1'b1;
        a_req = 4'b1010;
        a_data = {8'h33, 8'h00, 8'h11, 8'h00};
        @(negedge clk);
        check("midrst_wreq",  {31'b0, a_wreq}, 32'd0);
        check("midrst_busy",  {31'b0, a_busy}, 32'd0);
        check("midrst_ack",   {28'b0, a_ack}, 32'd0);
        check("midrst_wdata", {22'b0, a_wdata}, 32'd0);
        rsp_delay[0] = 0;
        rsp_base[0]  = 8'hE0;
        push_txn(0, 32'h111, 0, 4'b0010, 8'hE1);
        push_txn(0, 32'h333, 3, 4'b1000, 8'hE3);
        rst = 1'b0;
        wait_acks(0, 2, 40);
        a_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Width corner: 2 clients, 16-bit payload
        rsp_delay[2] = 0;
        rsp_base[2]  = 8'h5A;
        c_data = {16'hBEEF, 16'h1234};
        push_txn(2, 32'h1BEEF, 0, 4'b0010, 8'h5B);
        c_req = 2'b10;
        wait_acks(2, 1, 20);
        push_txn(2, 32'h01234, 3, 4'b0001, 8'h5A);
        push_txn(2, 32'h1BEEF, 3, 4'b0010, 8'h5B);
        c_req = 2'b11;
        wait_acks(2, 2, 40);
        c_req = 2'b00;
        repeat (4) @(negedge clk);

        check("grant_queue_empty", exp_grant.size(), 32'd0);
        check("ack_queue_empty",   exp_ack.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitrare_rr.md
Name: arbitrare_rr

Overview:
Parametrised N-client req/ack bus arbiter, the successor of the two-client arbiter. It accepts up to NUM_CLIENTS requesters and selects one per transaction, by round-robin or fixed priority. The winner's data, tagged with its client index, is forwarded to the single downstream winner_req/winner_ack target. The downstream ack data is returned to the granted client. It sits between the client request sources and the winner req/ack responder.

Parameters:
NUM_CLIENTS, 4, number of requesting clients (2..16)
REQ_DATA_WIDTH, 8, request payload width per client
ACK_DATA_WIDTH, 8, acknowledge payload width
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
ID_WIDTH, derived localparam, clog2(NUM_CLIENTS), minimum 1

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous reset, active high
client_req  input  NUM_CLIENTS  per-client request level; bit i = client i
client_data_req  input  NUM_CLIENTS*REQ_DATA_WIDTH  packed payloads; client i at [i*W +: W]
client_ack  output  NUM_CLIENTS  one-cycle acknowledge pulse to the granted client
client_data_ack  output  ACK_DATA_WIDTH  ack payload; valid only while a client_ack bit is high
winner_req  output  1  downstream request, held until winner_ack
winner_data_req  output  ID_WIDTH+REQ_DATA_WIDTH  {winner id (MSBs), captured payload (LSBs)}
winner_ack  input  1  downstream acknowledge pulse
winner_data_ack  input  ACK_DATA_WIDTH  downstream ack payload, valid with winner_ack
busy  output  1  high while in GRANT or RESP

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: client_ack=0, client_data_ack=0, winner_req=0, winner_data_req=0, busy=0, state=IDLE, rr_ptr=NUM_CLIENTS-1, mask_valid=0.
- Client rule: the client holds req high with stable data until it sees its ack bit. It may drop req in the cycle after ack, or keep it high to request again.
- States:
  - IDLE:
    - Samples eff_req = client_req & ~(mask_valid ? onehot(last_id) : 0).
    - If eff_req != 0, the next state is GRANT.
    - On that edge it registers winner id, captures that client's payload into winner_data_req, sets winner_req=1 and busy=1, and updates rr_ptr=id.
  - GRANT:
    - winner_req and winner_data_req are held stable.
    - On winner_ack=1 it registers client_data_ack=winner_data_ack, sets client_ack[id]=1 and winner_req=0, and moves to RESP.
  - RESP:
    - Lasts exactly one cycle, with the client_ack pulse visible.
    - The next state is IDLE, with client_ack=0, busy=0, and mask_valid=1 for exactly one IDLE cycle.
- Latency:
  - req high in an IDLE cycle gives winner_req high 1 cycle later.
  - winner_ack gives client_ack 1 cycle later.
  - The minimum transaction is 3 cycles req-to-ack with an immediate winner_ack.
- Round-robin selection:
  - The search starts at index rr_ptr+1, wraps modulo NUM_CLIENTS, and takes the first set eff_req bit.
  - After reset, client 0 has highest priority.
  - A client that is not requesting never blocks the others.
- Fixed mode: the lowest set eff_req index wins and rr_ptr is ignored. The mask still applies, so a continuously requesting client 0 cannot starve the others on back-to-back grants.
- Masking: only the just-served client is masked, and only for the first IDLE cycle after RESP. If it is the sole requester, it is granted one cycle later.
- Inputs ignored by state:
  - winner_ack in IDLE or RESP is ignored; no ack is generated.
  - client_req changes during GRANT/RESP are ignored; the payload is already captured.
  - A client dropping req while granted does not abort the transaction; its ack is still pulsed.
- Simultaneous events: a new request arriving in the same cycle as winner_ack is evaluated in the first IDLE cycle after RESP.
- Reset mid-operation: rst in any state forces reset values on the next edge. winner_req drops, no pending ack is delivered, and rr_ptr is restored.
- Widths:
  - winner_data_req MSBs = id zero-extended to ID_WIDTH.
  - For NUM_CLIENTS=2, ID_WIDTH=1, so the output is 1+REQ_DATA_WIDTH bits.
  - At most one client_ack bit is ever high (onehot0).

Test Plan:
- Single request: NUM_CLIENTS=4, reset, client_req=4'b0100, data2=8'hA5, winner_ack pulsed 2 cycles after winner_req -> winner_req=1 next cycle with winner_data_req=10'h2A5; client_ack=4'b0100 for 1 cycle; client_data_ack=winner_data_ack=8'h3C.
- Round-robin fairness: client_req=4'b1111 held, immediate winner_ack each grant -> grant order 0,1,2,3,0; each client_ack exactly one pulse per 4 transactions.
- Fixed priority with mask: PRIORITY_MODE=1, client_req=4'b0011 held -> grants alternate 0,1,0,1; with only client 0 requesting, consecutive grants are spaced by one masked IDLE cycle.
- Stray and late acks: winner_ack pulsed while IDLE -> no client_ack and no state change. Client drops req during GRANT -> ack still delivered to that client.
- Reset mid-transaction: rst asserted in GRANT -> next edge winner_req=0, busy=0, client_ack=0. After release with client_req=4'b1010, client 1 is granted first.
- Width corner: NUM_CLIENTS=2, REQ_DATA_WIDTH=16, client1 data 16'hBEEF -> winner_data_req=17'h1BEEF.
